// File: rtl/tcam_rule_writer.sv
// Rule-update and search front-end for top_tcam_mem: keeps a 64-entry ternary shadow table
// and rewrites the affected byte column of the tcam7x64 blocks on every insert/delete.
module tcam_rule_writer #(
   parameter int unsigned KEY_WIDTH   = 28,
   parameter int unsigned SLICE_WIDTH = 7,
   parameter int unsigned NUM_BLOCKS  = 4,
   parameter int unsigned NUM_RULES   = 64,
   parameter int unsigned DATA_WIDTH  = 32
) (
   input  logic                         in_clk,
   input  logic                         in_rst,
   input  logic                         in_req_valid,
   output logic                         out_req_ready,
   input  logic                         in_req_op,
   input  logic [$clog2(NUM_RULES)-1:0] in_req_idx,
   input  logic [KEY_WIDTH-1:0]         in_req_key,
   input  logic [KEY_WIDTH-1:0]         in_req_mask,
   input  logic                         in_search_valid,
   output logic                         out_search_ready,
   input  logic [KEY_WIDTH-1:0]         in_search_key,
   output logic                         out_search_issued,
   output logic                         out_busy,
   output logic                         out_done,
   output logic                         out_csb,
   output logic                         out_web,
   output logic [DATA_WIDTH/8-1:0]      out_wmask,
   output logic [KEY_WIDTH-1:0]         out_addr,
   output logic [DATA_WIDTH-1:0]        out_wdata
);

   localparam int unsigned IDX_W      = $clog2(NUM_RULES);
   localparam int unsigned BLK_W      = $clog2(NUM_BLOCKS);
   localparam int unsigned ROW_W      = SLICE_WIDTH;
   localparam int unsigned LANES      = DATA_WIDTH / 8;
   localparam int unsigned LANE_W     = $clog2(LANES);
   localparam int unsigned SEL_W      = 3;
   localparam int unsigned GRP_W      = IDX_W - SEL_W;
   localparam int unsigned CNT_W      = BLK_W + 1 + ROW_W;
   localparam int unsigned CLEAR_LAST = (1 << CNT_W) - 1;
   localparam int unsigned WRITE_LAST = (1 << (BLK_W + ROW_W)) - 1;

   typedef enum logic [2:0] {
      CLEAR,
      IDLE,
      LOAD,
      WRITE,
      DONE
   } state_t;

   state_t                 state, state_nx;
   logic [CNT_W-1:0]       cnt, cnt_nx;

   // Shadow rule table
   logic [NUM_RULES-1:0]   valid_tab;
   logic [KEY_WIDTH-1:0]   key_tab  [NUM_RULES];
   logic [KEY_WIDTH-1:0]   mask_tab [NUM_RULES];

   // Latched update request
   logic                   op_q;
   logic [IDX_W-1:0]       idx_q;
   logic [KEY_WIDTH-1:0]   key_q;
   logic [KEY_WIDTH-1:0]   mask_q;

   logic                   req_accept, search_accept;
   logic [BLK_W-1:0]       blk;
   logic [ROW_W-1:0]       row;
   logic [IDX_W-1:0]       rule;
   logic [ROW_W-1:0]       kslice, mslice;
   logic [7:0]             line_byte;

   logic                   csb_nx, web_nx, issued_nx, done_nx, busy_nx;
   logic                   req_ready_nx, search_ready_nx;
   logic [LANES-1:0]       wmask_nx;
   logic [KEY_WIDTH-1:0]   addr_nx;
   logic [DATA_WIDTH-1:0]  wdata_nx;

   always_ff @(posedge in_clk) begin
      if (in_rst) begin
         state <= CLEAR;
         cnt   <= '0;
      end else begin
         state <= state_nx;
         cnt   <= cnt_nx;
      end
   end

   // Next state, arbitration and next port values
   always_comb begin
      state_nx        = state;
      cnt_nx          = cnt;
      csb_nx          = 1'b1;
      web_nx          = 1'b1;
      wmask_nx        = '0;
      addr_nx         = '0;
      wdata_nx        = '0;
      issued_nx       = 1'b0;
      done_nx         = 1'b0;
      busy_nx         = 1'b0;
      req_ready_nx    = 1'b0;
      search_ready_nx = 1'b0;
      req_accept      = 1'b0;
      search_accept   = 1'b0;
      blk             = cnt[ROW_W +: BLK_W];
      row             = cnt[ROW_W-1:0];
      rule            = '0;
      kslice          = '0;
      mslice          = '0;
      line_byte       = '0;

      // Byte lane for the current (block,row): bit j is rule group*8+j matching row in this block
      for (int j = 0; j < 8; j++) begin
         rule         = {idx_q[IDX_W-1 -: GRP_W], SEL_W'(j)};
         kslice       = ROW_W'(key_tab[rule]  >> (int'(blk) * SLICE_WIDTH));
         mslice       = ROW_W'(mask_tab[rule] >> (int'(blk) * SLICE_WIDTH));
         line_byte[j] = valid_tab[rule] && (((row ^ kslice) & ~mslice) == '0);
      end

      case (state)
         CLEAR: begin
            busy_nx  = 1'b1;
            csb_nx   = 1'b0;
            web_nx   = 1'b0;
            wmask_nx = '1;
            addr_nx  = KEY_WIDTH'(cnt);
            cnt_nx   = cnt + CNT_W'(1);
            if (cnt == CNT_W'(CLEAR_LAST)) begin
               state_nx = IDLE;
               cnt_nx   = '0;
            end
         end
         IDLE: begin
            // Search wins the port whenever both are pending
            search_accept = out_search_ready && in_search_valid;
            req_accept    = out_search_ready && in_req_valid && !in_search_valid;
            if (search_accept) begin
               csb_nx    = 1'b0;
               web_nx    = 1'b1;
               addr_nx   = in_search_key;
               issued_nx = 1'b1;
            end
            if (req_accept) begin
               state_nx = LOAD;
            end
            search_ready_nx = !req_accept;
            req_ready_nx    = !req_accept && !in_search_valid;
         end
         LOAD: begin
            busy_nx  = 1'b1;
            cnt_nx   = '0;
            state_nx = WRITE;
         end
         WRITE: begin
            busy_nx  = 1'b1;
            csb_nx   = 1'b0;
            web_nx   = 1'b0;
            wmask_nx = LANES'(1) << idx_q[SEL_W +: LANE_W];
            addr_nx  = KEY_WIDTH'({blk, idx_q[IDX_W-1], row});
            wdata_nx = {LANES{line_byte}};
            cnt_nx   = cnt + CNT_W'(1);
            if (cnt == CNT_W'(WRITE_LAST)) begin
               state_nx = DONE;
               cnt_nx   = '0;
            end
         end
         DONE: begin
            done_nx  = 1'b1;
            state_nx = IDLE;
         end
         default: begin
            state_nx = CLEAR;
            cnt_nx   = '0;
         end
      endcase
   end

   always_ff @(posedge in_clk) begin
      if (in_rst) begin
         out_csb           <= 1'b1;
         out_web           <= 1'b1;
         out_wmask         <= '0;
         out_addr          <= '0;
         out_wdata         <= '0;
         out_search_issued <= 1'b0;
         out_done          <= 1'b0;
         out_busy          <= 1'b1;
         out_req_ready     <= 1'b0;
         out_search_ready  <= 1'b0;
      end else begin
         out_csb           <= csb_nx;
         out_web           <= web_nx;
         out_wmask         <= wmask_nx;
         out_addr          <= addr_nx;
         out_wdata         <= wdata_nx;
         out_search_issued <= issued_nx;
         out_done          <= done_nx;
         out_busy          <= busy_nx;
         out_req_ready     <= req_ready_nx;
         out_search_ready  <= search_ready_nx;
      end
   end

   always_ff @(posedge in_clk) begin
      if (req_accept) begin
         op_q   <= in_req_op;
         idx_q  <= in_req_idx;
         key_q  <= in_req_key;
         mask_q <= in_req_mask;
      end
   end

   always_ff @(posedge in_clk) begin
      if (in_rst) begin
         valid_tab <= '0;
      end else if (state == LOAD) begin
         valid_tab[idx_q] <= op_q;
      end
   end

   // A delete keeps the stale key/mask; only the valid bit gates it out
   always_ff @(posedge in_clk) begin
      if (state == LOAD && op_q) begin
         key_tab[idx_q]  <= key_q;
         mask_tab[idx_q] <= mask_q;
      end
   end

endmodule

// File: doc/tcam_rule_writer.md
Name: tcam_rule_writer

Overview:
- Update and search front-end directly upstream of top_tcam_mem. Drives its in_csb/in_web/in_wmask/in_addr/in_wdata port.
- Keeps a shadow table of 64 ternary rules (28-bit key, 28-bit mask, valid bit).
- On an insert or delete, rewrites the affected 8-rule byte column across all 4 blocks x 128 rows of the tcam7x64 SRAMs.
- Arbitrates search requests onto the same memory port. After reset, sweeps every memory word to zero before accepting traffic.

Parameters:
- KEY_WIDTH, 28, search key width; equals NUM_BLOCKS*SLICE_WIDTH.
- SLICE_WIDTH, 7, key bits per block; row address width.
- NUM_BLOCKS, 4, number of tcam7x64 blocks.
- NUM_RULES, 64, rule capacity; rule index width 6.
- DATA_WIDTH, 32, memory write word width; 4 byte lanes.

Ports:
- in_clk  input  1  clock, rising edge
- in_rst  input  1  synchronous reset, active-high
- in_req_valid  input  1  rule update request valid
- out_req_ready  output  1  update request accepted when valid&ready
- in_req_op  input  1  1=insert/overwrite, 0=delete
- in_req_idx  input  6  rule index; lower index = higher priority downstream
- in_req_key  input  28  rule key
- in_req_mask  input  28  per-bit don't-care, 1=ignore bit
- in_search_valid  input  1  search request valid
- out_search_ready  output  1  search accepted when valid&ready
- in_search_key  input  28  search key
- out_search_issued  output  1  pulse: memory port carries a search this cycle
- out_busy  output  1  high in CLEAR, LOAD, WRITE
- out_done  output  1  one-cycle pulse when an update sweep completes
- out_csb  output  1  to top_tcam_mem in_csb, active-low
- out_web  output  1  to top_tcam_mem in_web, 1=read/search, 0=write
- out_wmask  output  4  byte write mask
- out_addr  output  28  memory address or search key
- out_wdata  output  32  write data

Behaviour:
- One clock (in_clk). Reset is synchronous and active-high (in_rst). All outputs are registered.
- Idle port values: out_csb=1, out_web=1, out_wmask=0, out_addr=0, out_wdata=0.
- Reset values:
  - state=CLEAR; counter=0.
  - All 64 valid bits cleared.
  - out_done=0, out_search_issued=0, out_req_ready=0, out_search_ready=0.
  - Port at idle values.
- Write address map: out_addr[9:8]=block, out_addr[7]=word half (0 = rule bits 31:0, 1 = rule bits 63:32), out_addr[6:0]=row, out_addr[27:10]=0.
- State machine, states CLEAR, IDLE, LOAD, WRITE, DONE:
- CLEAR:
  - 10-bit counter c runs 0..1023; one write per cycle.
  - out_addr[9:0]=c, out_wmask=4'hF, out_wdata=0, out_csb=0, out_web=0.
  - After c=1023 go to IDLE. Sweep lasts 1024 cycles starting the cycle after reset deasserts.
- IDLE:
  - out_search_ready=1.
  - out_req_ready = ~in_search_valid, so search has priority. Update starvation under continuous search is accepted.
  - On search accept: next cycle out_csb=0, out_web=1, out_addr=in_search_key, out_search_issued=1. Back-to-back searches every cycle are allowed.
  - On update accept: latch op/idx/key/mask, then go to LOAD.
- LOAD (1 cycle): update the shadow entry.
  - Insert: key/mask written, valid=1.
  - Delete: valid=0; key/mask kept.
  - Port idle.
- WRITE (512 cycles):
  - Counter {block[1:0], row[6:0]}, row fastest.
  - Per cycle: out_addr={block, idx[5], row}; out_wmask=one-hot(idx[4:3]); out_wdata={4{byte}}; out_csb=0, out_web=0.
  - byte bit j = valid[g*8+j] AND (((row XOR key_j[7*block+6:7*block]) AND NOT mask_j[7*block+6:7*block]) == 0), where g=idx[5:3].
  - The shadow read uses the post-LOAD contents.
- DONE (1 cycle): out_done=1, port idle, then IDLE.
- out_busy=1 in CLEAR, LOAD, WRITE; 0 in IDLE, DONE.
- Both ready outputs are 0 outside IDLE.
- Timing: update accepted at cycle T gives LOAD at T+1, writes at T+2..T+513, out_done at T+514, ready again at T+515.
- Insert on an already-valid index overwrites it. Delete of an invalid index still performs the full sweep.
- Reset at any point, including mid-WRITE: abort immediately; no out_done; valid cleared; restart CLEAR.

Test Plan:
1. Reset deassert -> 1024 consecutive writes, addr 0..1023 ascending, wmask F, wdata 0; out_req_ready rises on cycle 1025; out_busy high throughout.
2. Insert idx 5, key 0x0000081, mask 0:
   - Writes at block0/row1 (addr 0x001) and block1/row1 (addr 0x101) carry wdata 0x20202020, wmask 4'b0001.
   - Blocks 2 and 3 write wdata 0x20202020 at row 0 (addr 0x200, 0x300).
   - All other rows carry wdata 0.
   - out_done at T+514.
3. Insert idx 40, key 0, mask 0x000007F:
   - Block 0: all 128 rows addr 0x080..0x0FF carry wdata 0x01010101, wmask 4'b0010.
   - Blocks 1-3: only row 0 (addr 0x180, 0x280, 0x380) nonzero.
4. Delete idx 5 after step 2 -> all 512 writes to group 0 carry wdata 0, wmask 4'b0001.
5. in_search_valid and in_req_valid together in IDLE, key 0xABCDEF1:
   - Next cycle: out_web=1, out_csb=0, out_addr=0xABCDEF1, out_search_issued=1.
   - Request accepted the first cycle in_search_valid is low.
6. in_rst pulsed at write 200 of an update sweep:
   - Port goes to CLEAR writes the next cycle; out_done never pulses.
   - A search for the previously inserted key later finds no bits set.
